seg7_display_driver: RTL and testbench
======================================

// Module: seg7_display_driver
// PURPOSE
//  Downstream of the calculator FSM. Takes the signed 32-bit displayedNum and
//  converts it to decimal with a sequential double-dabble (one shift per clock).
//  Formats the result (sign, leading-zero blanking, overflow "Err") and drives an
//  8-digit, time-multiplexed, common-anode 7-segment display.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles each digit stays enabled; >=2
// PORTS
//  clk    in   1   system clock
//  rst    in   1   reset, synchronous, active-high
//  value  in   32  two's-complement number to show (calculator displayedNum)
//  load   in   1   1-cycle strobe: capture value and convert it
//  busy   out  1   conversion in progress
//  an     out  8   digit enables, active-low; an[0] = rightmost digit
//  seg    out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp     out  1   decimal point, active-low; held 1 (off)
// BEHAVIOUR
//  Reset (clk edge with rst=1), values from the next cycle:
//  - busy=0, an=8'hFF, seg=7'h7F, dp=1.
//  - Display buffer all blank. Scan counter and digit index = 0. Pending flag clear.
//  - rst overrides everything, including a conversion in flight, which is discarded.
//  FSM: IDLE -> CONV (32 cycles) -> FMT (1 cycle) -> IDLE.
//  - IDLE + load: capture sign=value[31] and mag=|value| as 32-bit unsigned
//    (-2^31 -> 32'h8000_0000). Clear the 40-bit BCD register. Go to CONV.
//  - CONV, each cycle:
//    - add 3 to every BCD nibble >= 5;
//    - shift {bcd,mag} left by 1;
//    - 5-bit iteration counter counts 0..31; leave CONV after iteration 31.
//  - FMT: write the 8-entry display buffer (see format rules), then go to IDLE.
//  - busy=1 exactly while in CONV or FMT. Load at cycle N gives busy in cycles
//    N+1..N+33; buffer updated at the edge ending cycle N+33.
//  - load while busy: latch value into the pending register (last load wins),
//    set pending. On leaving FMT with pending set, go straight to CONV for the
//    pending value; busy stays high with no gap. Load in the same cycle as FMT
//    counts as pending.
//  Format (BCD digits d9..d0, d0 least significant):
//  - Overflow if d9|d8 != 0, or sign=1 and d7 != 0. Buffer positions 7..0 then
//    show: blank x5, 'E', 'r', 'r'.
//  - Otherwise: the MS digit is the highest nonzero digit (d0 if the value is
//    0). Digits above it are blank, the MS digit and those below are shown.
//  - If sign=1, put '-' in the position directly left of the MS digit.
//  - -0 cannot occur.
//  Segment codes:
//  - Digits 0-9: 40,79,24,30,19,12,02,78,00,10 (hex).
//  - '-'=3F, blank=7F, 'E'=06, 'r'=2F.
//  Scan:
//  - Free-running counter 0..REFRESH_DIV-1. On wrap, digit index goes 0..7 then
//    back to 0.
//  - an = ~(8'b1 << idx); seg = code of buffer[idx]; both registered.
//  - Scanning runs regardless of busy. The buffer only changes in FMT, so
//    there is no tearing.
// TESTING
//  - Reset, then check: an=FF, seg=7F, busy=0. Load 0 -> after 34 cycles
//    buffer = blank x7 + '0'; over 8*REFRESH_DIV cycles only an[0] shows seg=40.
//  - Load 123 at cycle N -> busy high for cycles N+1..N+33, then low. Buffer =
//    blank x5 + '1','2','3'.
//  - Load -4567 -> buffer = blank x3 + '-','4','5','6','7'. Load 99999999 -> all
//    eight digits '9'.
//  - Load -10000000 -> 'Err'. Load 32'h8000_0000 -> 'Err'. Load -9999999 ->
//    '-' plus seven '9'.
//  - Load 5, then load 7 and 8 while busy -> busy stays high continuously and the
//    final buffer shows '8'. The displayed '5' buffer exists for at least 1 cycle.
//  - rst mid-CONV -> busy=0 next cycle, buffer blank, no update. Then load 42 ->
//    correct '42' after 34 cycles.
//  - Check the scan with REFRESH_DIV=4: an steps FE,FD,...,7F every 4 cycles and
//    wraps back to FE.

Source files
------------

// File: rtl/seg7_display_driver.sv
// Signed 32-bit to decimal via sequential double-dabble, formatted onto an
// 8-digit multiplexed common-anode 7-segment display.
module seg7_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        load,
  output logic        busy,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_FMT
  } state_t;

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  localparam logic [6:0] C_BLANK = 7'h7F;
  localparam logic [6:0] C_MINUS = 7'h3F;
  localparam logic [6:0] C_E     = 7'h06;
  localparam logic [6:0] C_R     = 7'h2F;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [39:0] bcd_q, bcd_d;
  logic        sign_q, sign_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [31:0] pval_q, pval_d;
  logic [6:0]  buf_q [8];
  logic [6:0]  buf_d [8];
  logic [CW-1:0] scan_q, scan_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  logic        start;
  logic [31:0] start_val;
  logic [39:0] adj;
  logic [6:0]  fbuf [8];
  logic        ovf;
  logic [2:0]  ms;

  function automatic logic [6:0] dig_code(input logic [3:0] d);
    case (d)
      4'd0:    dig_code = 7'h40;
      4'd1:    dig_code = 7'h79;
      4'd2:    dig_code = 7'h24;
      4'd3:    dig_code = 7'h30;
      4'd4:    dig_code = 7'h19;
      4'd5:    dig_code = 7'h12;
      4'd6:    dig_code = 7'h02;
      4'd7:    dig_code = 7'h78;
      4'd8:    dig_code = 7'h00;
      4'd9:    dig_code = 7'h10;
      default: dig_code = C_BLANK;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 10; i++) begin
      adj[4*i+:4] = (bcd_q[4*i+:4] >= 4'd5) ?
                    bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    end
  end

  // Formatting of the finished BCD result into segment codes.
  always_comb begin
    ovf = (bcd_q[39:32] != 8'd0) ||
          (sign_q && (bcd_q[31:28] != 4'd0));
    ms = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i+:4] != 4'd0) ms = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      if (ovf) begin
        fbuf[i] = C_BLANK;
      end else if (i <= int'(ms)) begin
        fbuf[i] = dig_code(bcd_q[4*i+:4]);
      end else if (sign_q && (i == int'(ms) + 1)) begin
        fbuf[i] = C_MINUS;
      end else begin
        fbuf[i] = C_BLANK;
      end
    end
    if (ovf) begin
      fbuf[2] = C_E;
      fbuf[1] = C_R;
      fbuf[0] = C_R;
    end
  end

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    bcd_d     = bcd_q;
    sign_d    = sign_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pval_d    = pval_q;
    buf_d     = buf_q;
    start     = 1'b0;
    start_val = value;
    unique case (state_q)
      S_IDLE: begin
        if (load) start = 1'b1;
      end
      S_CONV: begin
        {bcd_d, mag_d} = {adj[38:0], mag_q, 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FMT;
        if (load) begin
          pend_d = 1'b1;
          pval_d = value;
        end
      end
      S_FMT: begin
        buf_d   = fbuf;
        state_d = S_IDLE;
        // A load landing in this cycle is newer than anything pending.
        if (load || pend_q) begin
          start     = 1'b1;
          start_val = load ? value : pval_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      sign_d  = start_val[31];
      mag_d   = start_val[31] ? (~start_val + 32'd1) : start_val;
      bcd_d   = 40'd0;
      cnt_d   = 5'd0;
      pend_d  = 1'b0;
      state_d = S_CONV;
    end
  end

  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == CW'(REFRESH_DIV - 1)) begin
      scan_d = '0;
      idx_d  = idx_q + 3'd1;
    end
    an_d  = ~(8'b1 << idx_q);
    seg_d = buf_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mag_q   <= 32'd0;
      bcd_q   <= 40'd0;
      sign_q  <= 1'b0;
      cnt_q   <= 5'd0;
      pend_q  <= 1'b0;
      pval_q  <= 32'd0;
      for (int i = 0; i < 8; i++) buf_q[i] <= C_BLANK;
      scan_q  <= '0;
      idx_q   <= 3'd0;
      an_q    <= 8'hFF;
      seg_q   <= C_BLANK;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
      buf_q   <= buf_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_seg7_display_driver.sv
// Scoreboard bench for seg7_display_driver: expected display images are
// queued at load time and compared against the scanned an/seg outputs.
module tb_seg7_display_driver;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic        load;
  logic        busy;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_vec = 0;
  int n_err = 0;
  logic [55:0] exp_q [$];

  always #5 clk = ~clk;

  seg7_display_driver #(.REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .busy  (busy),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  function automatic logic [6:0] code_of(input int d);
    case (d)
      0: code_of = 7'h40;
      1: code_of = 7'h79;
      2: code_of = 7'h24;
      3: code_of = 7'h30;
      4: code_of = 7'h19;
      5: code_of = 7'h12;
      6: code_of = 7'h02;
      7: code_of = 7'h78;
      8: code_of = 7'h00;
      default: code_of = 7'h10;
    endcase
  endfunction

  function automatic logic [55:0] blank_img();
    blank_img = {8{7'h7F}};
  endfunction

  function automatic logic [55:0] model(input logic [31:0] v);
    logic [55:0] r;
    longint m, t;
    int nd;
    bit s;
    s = v[31];
    m = longint'({32'd0, v});
    if (s) m = 64'sh1_0000_0000 - m;
    r = blank_img();
    if (m >= 100000000 || (s && m >= 10000000)) begin
      r[2*7+:7] = 7'h06;
      r[1*7+:7] = 7'h2F;
      r[0*7+:7] = 7'h2F;
    end else begin
      nd = 1;
      t = m;
      while (t >= 10) begin
        t = t / 10;
        nd++;
      end
      t = m;
      for (int i = 0; i < nd; i++) begin
        r[i*7+:7] = code_of(int'(t % 10));
        t = t / 10;
      end
      if (s) r[nd*7+:7] = 7'h3F;
    end
    return r;
  endfunction

  task automatic do_load(input logic [31:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    exp_q.push_back(model(v));
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int g = 0; g < 200 && busy; g++) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic capture_check(input string name);
    logic [6:0]  obs [8];
    logic [7:0]  m;
    logic [55:0] e;
    for (int k = 0; k < 8; k++) obs[k] = 7'h55;
    repeat (2) @(negedge clk);
    repeat (10 * RD) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        m = ~(8'b1 << k);
        if (an == m) obs[k] = seg;
      end
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: no expected image queued", name);
    end else begin
      e = exp_q.pop_front();
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (obs[k] !== e[k*7+:7]) begin
          n_err++;
          $display("FAIL %s digit %0d: got %h want %h",
                   name, k, obs[k], e[k*7+:7]);
        end
      end
    end
  endtask

  task automatic check_busy(input string name, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s busy cycles: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    load  = 1'b0;
    value = 32'd0;
    repeat (2) @(negedge clk);
    n_vec += 4;
    if (an !== 8'hFF) begin
      n_err++; $display("FAIL reset an: got %h want ff", an);
    end
    if (seg !== 7'h7F) begin
      n_err++; $display("FAIL reset seg: got %h want 7f", seg);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset busy: got %b want 0", busy);
    end
    if (dp !== 1'b1) begin
      n_err++; $display("FAIL reset dp: got %b want 1", dp);
    end
    rst = 1'b0;
    exp_q.push_back(blank_img());
    capture_check("reset_blank");
  endtask

  task automatic test_single(input logic [31:0] v, input string name);
    int n;
    do_load(v);
    wait_idle(n);
    check_busy(name, n, 33);
    capture_check(name);
  endtask

  task automatic test_values();
    logic [31:0] vals [8];
    vals[0] = -32'sd4567;
    vals[1] = 32'd99999999;
    vals[2] = -32'sd10000000;
    vals[3] = 32'h8000_0000;
    vals[4] = -32'sd9999999;
    vals[5] = 32'd10000000;
    vals[6] = 32'd100000000;
    vals[7] = -32'sd1;
    for (int i = 0; i < 8; i++) test_single(vals[i], $sformatf("val%0d", i));
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    value = 32'd5;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    exp_q.push_back(model(32'd8));
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (!busy) break;
      n++;
      if (k == 10) begin
        value = 32'd7; load = 1'b1;
      end else if (k == 20) begin
        value = 32'd8; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check_busy("b2b", n, 66);
    capture_check("b2b");
  endtask

  task automatic test_load_in_fmt();
    int n;
    @(negedge clk);
    value = 32'd1;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    exp_q.push_back(model(32'd2));
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (!busy) break;
      n++;
      if (k == 32) begin
        value = 32'd2; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check_busy("fmt_load", n, 66);
    capture_check("fmt_load");
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    value = 32'd555;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL rst_mid busy: got %b want 0", busy);
    end
    exp_q.push_back(blank_img());
    capture_check("rst_mid_blank");
    test_single(32'd42, "after_rst_42");
  endtask

  task automatic test_scan();
    logic [7:0] prev;
    logic [7:0] want;
    bit found;
    found = 0;
    prev  = an;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (an == 8'hFE && prev != 8'hFE) begin
        found = 1;
        break;
      end
      prev = an;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL scan sync: an=%h never stepped to fe", an);
    end else begin
      for (int j = 0; j < 9 * RD; j++) begin
        want = ~(8'b1 << ((j / RD) % 8));
        n_vec++;
        if (an !== want) begin
          n_err++;
          $display("FAIL scan step %0d: got %h want %h", j, an, want);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(32'd0, "zero");
    test_single(32'd123, "v123");
    test_values();
    test_back_to_back();
    test_load_in_fmt();
    test_rst_mid();
    test_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
